// File: rtl/seg_scan_if.sv
// Segment scanner bus: per-frame digit data and mask in, multiplexed segment/digit-select out.
// The controller side (master) drives the data; the scanner (slave) drives the display pins.
interface seg_scan_if #(
  parameter int DIGITS = 6
);
  logic                  enable;
  logic [8*DIGITS-1:0]   seg_in;
  logic [DIGITS-1:0]     blink_mask;
  logic [7:0]            seg_out;
  logic [DIGITS-1:0]     digit_sel;
  logic                  frame_start;

  modport master (
    output enable, seg_in, blink_mask,
    input  seg_out, digit_sel, frame_start
  );

  modport slave (
    input  enable, seg_in, blink_mask,
    output seg_out, digit_sel, frame_start
  );
endinterface

// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner: one digit per SCAN_DIV-cycle slot, a blank gap at the
// start of each slot, frame-level snapshot of the inputs and a frame-counted blink phase.
module seg_scan_mux #(
  parameter int DIGITS       = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic     clk,
  input  logic     rst,
  seg_scan_if.slave bus
);
  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  logic                  boff_q, boff_d;
  logic [8*DIGITS-1:0]   snap_q, snap_d;
  logic [DIGITS-1:0]     msnap_q, msnap_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic                  fs_q, fs_d;

  logic cnt_last, idx_last, frame_first, in_blank;

  function automatic logic [7:0] seg_byte(input logic [8*DIGITS-1:0] v,
                                          input logic [IDX_W-1:0] i);
    return v[8*int'(i) +: 8];
  endfunction

  assign cnt_last    = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign idx_last    = (idx_q == IDX_W'(DIGITS - 1));
  assign frame_first = (cnt_q == '0) && (idx_q == '0);

  // A zero-length gap must not produce an always-false unsigned compare.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt_q < CNT_W'(BLANK_CYCLES));
    end
  endgenerate

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fcnt_d  = fcnt_q;
    boff_d  = boff_q;
    snap_d  = snap_q;
    msnap_d = msnap_q;
    seg_d   = '0;
    sel_d   = '0;
    fs_d    = 1'b0;
    if (!bus.enable) begin
      cnt_d = '0;
      idx_d = '0;
    end else begin
      if (frame_first) begin
        snap_d  = bus.seg_in;
        msnap_d = bus.blink_mask;
        fs_d    = 1'b1;
      end
      if (cnt_last) begin
        cnt_d = '0;
        idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
        if (idx_last) begin
          if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
            fcnt_d = '0;
            boff_d = ~boff_q;
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // The freshly captured snapshot is shown on the snapshot edge itself.
      if (!in_blank) begin
        sel_d = DIGITS'(1) << idx_q;
        seg_d = (boff_q && msnap_d[idx_q]) ? 8'h00 : seg_byte(snap_d, idx_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      fcnt_q  <= '0;
      boff_q  <= 1'b0;
      snap_q  <= '0;
      msnap_q <= '0;
      seg_q   <= '0;
      sel_q   <= '0;
      fs_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      boff_q  <= boff_d;
      snap_q  <= snap_d;
      msnap_q <= msnap_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.seg_out     = seg_q;
  assign bus.digit_sel   = sel_q;
  assign bus.frame_start = fs_q;
endmodule
